timed_event_fifo: RTL and testbench
===================================

# timed_event_fifo

- Parametrised successor to the single-width event FIFO; carries the same packed `{payload, lt}` entries, generalised in payload width, delay width and depth.
- Adds per-entry release timing: each entry is held until its `lt` delay field has elapsed.
- Adds an occupancy count and an almost-full flag.
- Sits between the spike/event generators and the neuron update pipeline, delaying events by their programmed latency while preserving arrival order.

## Interface
- `DATA_WIDTH`, 16, payload bits.
- `LT_WIDTH`, 16, delay-field bits; also the width of the internal timestamp.
- `ADDR_LEN`, 8, log2 of depth.
- `NUM_ENTRIES`, 256, depth; must equal 2^`ADDR_LEN`.
- `AFULL_LEVEL`, 240, count at or above which `almost_full` asserts.
- `clk`, in, 1, sole clock, rising edge.
- `reset`, in, 1, asynchronous, active-high.
- `enqueue`, in, 1, write request.
- `dequeue`, in, 1, read request.
- `data_in`, in, `DATA_WIDTH`+`LT_WIDTH`, `{payload, lt}`, payload in the MSBs.
- `data_out`, out, `DATA_WIDTH`, head payload (show-ahead).
- `valid`, out, 1, head entry is present and released.
- `full`, out, 1, count == `NUM_ENTRIES`.
- `empty`, out, 1, count == 0.
- `almost_full`, out, 1, count >= `AFULL_LEVEL`.
- `count`, out, `ADDR_LEN`+1, current occupancy.

## Operation
- Storage: circular buffer with `ADDR_LEN`-bit read/write pointers; occupancy kept in `count`.
  - Each slot holds the payload plus a `LT_WIDTH`-bit release stamp.
- Timestamp `now`: free-running `LT_WIDTH`-bit counter, +1 every cycle, wraps modulo 2^`LT_WIDTH`.
- Enqueue is accepted when `enqueue && (!full || deq_acc)`.
  - On acceptance: store the payload and `release = now + lt + 1` (mod 2^`LT_WIDTH`), then advance the write pointer.
- Release test is wrap-safe: the head is released when the MSB of `(now - release_head)` is 0.
  - `lt` must be < 2^(`LT_WIDTH`-1); larger values are undefined behaviour.
- `valid = !empty && released(head)`.
- Dequeue is accepted (`deq_acc`) when `dequeue && valid`; it advances the read pointer.
  - `dequeue` while `!valid` is ignored and changes no state.
- Strict arrival order:
  - A later entry with a shorter `lt` waits behind the head (head-of-line blocking).
  - Once the head is popped, any later entry whose stamp has already passed is valid in the next cycle.
- `data_out` = head payload when `!empty`, else 0.
- Count update:
  - +1 on an accepted enqueue alone.
  - -1 on an accepted dequeue alone.
  - Unchanged when both are accepted.
- Boundaries:
  - Full with `enqueue` only: write dropped, state unchanged.
  - Full with an accepted dequeue plus `enqueue`: both happen, `full` stays 1.
  - Empty with `enqueue` and `dequeue`: enqueue only; a new entry is never popped in the cycle it is written.
  - Pointer wrap at `NUM_ENTRIES`-1 to 0 is transparent.
  - `reset` mid-operation: all entries discarded immediately; `now` cleared.

## Timing
- Reset values:
  - `data_out` = 0, `valid` = 0, `full` = 0, `empty` = 1, `almost_full` = 0, `count` = 0.
  - Pointers = 0, `now` = 0.
- Registered outputs: `full`, `empty`, `almost_full`, `count` are registered and update on the edge that accepts the operation.
- Combinational outputs: `data_out` and `valid` are combinational from registered state (memory read, `now`, read pointer).
- Enqueue edge E with delay L: the entry becomes visible at the head (if it is the oldest) in the cycle after E.
  - It is released L cycles after that cycle; L = 0 gives `valid` in the first cycle after E.
- Throughput: one enqueue and one dequeue per cycle.

## Configuration
- `TIMED_FIFO_DELAY_EN` defined:
  - Timestamp counter, release stamps and the gating described above are compiled in.
- `TIMED_FIFO_DELAY_EN` undefined:
  - Plain FIFO: `valid = !empty`, the `lt` bits are accepted but ignored.
  - No timestamp storage or counter is generated.
  - All other ports and flags behave identically.

## Test plan
- Reset for 2 cycles, release → `empty`=1, `valid`=0, `count`=0, `data_out`=0.
- Enqueue payloads 10, 11, 12, each with lt=1, on consecutive edges; hold `dequeue`=1 afterwards → 10, 11, 12 pop in order.
  - Each is valid 1 cycle after its head-visible cycle.
  - `empty`=1 after the third pop.
- Enqueue (10, lt=1), (11, lt=4), (12, lt=2), then hold dequeue → 10 pops at E0+2, 11 at E1+5; 12 is valid the cycle after 11 pops (its stamp has already passed).
- Fill 256 entries with lt=0 → `full`=1, `almost_full` set at count 240.
  - An extra enqueue is dropped.
  - Simultaneous enqueue and dequeue keeps `count`=256 with the new payload at the tail.
- Run `now` past 0xFFFF, enqueue lt=5 at `now`=0xFFFD → release at 0x0003 (wrapped), `valid` exactly then.
- Assert `reset` with 5 entries queued → outputs return to reset values asynchronously; a fresh enqueue afterwards pops correctly.
- Rebuild without `TIMED_FIFO_DELAY_EN` → lt=100 entries are valid the cycle after write.

Source files
------------

// File: rtl/timed_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : timed_event_fifo
// Description : Show-ahead event FIFO that holds each {payload, lt} entry
//               until lt cycles have elapsed. Release timing is compiled in
//               only when TIMED_FIFO_DELAY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module timed_event_fifo #(
    parameter int DATA_WIDTH  = 16,
    parameter int LT_WIDTH    = 16,
    parameter int ADDR_LEN    = 8,
    parameter int NUM_ENTRIES = 256,
    parameter int AFULL_LEVEL = 240
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enqueue,
    input  logic                           dequeue,
    input  logic [DATA_WIDTH+LT_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           valid,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic [ADDR_LEN:0]              count
);

    localparam logic [ADDR_LEN:0] c_full_count  = (ADDR_LEN+1)'(NUM_ENTRIES);
    localparam logic [ADDR_LEN:0] c_afull_count = (ADDR_LEN+1)'(AFULL_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [NUM_ENTRIES];
    logic [ADDR_LEN-1:0]   r_wr_ptr;
    logic [ADDR_LEN-1:0]   r_rd_ptr;
    logic [ADDR_LEN:0]     r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;

    logic                  w_released;
    logic                  w_valid;
    logic                  w_deq_acc;
    logic                  w_enq_acc;
    logic [ADDR_LEN:0]     w_count_nxt;

`ifdef TIMED_FIFO_DELAY_EN
    logic [LT_WIDTH-1:0] r_now;
    logic [LT_WIDTH-1:0] r_stamp [NUM_ENTRIES];
    logic [LT_WIDTH-1:0] w_age;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_now <= '0;
        end else begin
            r_now <= r_now + LT_WIDTH'(1);
        end
    end

    // Stamp is the first cycle in which the entry may leave; the +1 accounts
    // for the write edge itself.
    always_ff @(posedge clk) begin
        if (w_enq_acc) begin
            r_stamp[r_wr_ptr] <= r_now + data_in[LT_WIDTH-1:0] + LT_WIDTH'(1);
        end
    end

    // Signed-distance compare keeps the release test correct across wrap.
    assign w_age      = r_now - r_stamp[r_rd_ptr];
    assign w_released = ~w_age[LT_WIDTH-1];
`else
    logic w_unused_lt;
    assign w_unused_lt = ^data_in[LT_WIDTH-1:0];
    assign w_released  = 1'b1;
`endif

    assign w_valid   = ~r_empty & w_released;
    assign w_deq_acc = dequeue & w_valid;
    assign w_enq_acc = enqueue & (~r_full | w_deq_acc);

    always_comb begin
        w_count_nxt = r_count;
        if (w_enq_acc && !w_deq_acc) begin
            w_count_nxt = r_count + (ADDR_LEN+1)'(1);
        end else if (!w_enq_acc && w_deq_acc) begin
            w_count_nxt = r_count - (ADDR_LEN+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq_acc) begin
            r_mem[r_wr_ptr] <= data_in[DATA_WIDTH+LT_WIDTH-1:LT_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
        end else begin
            if (w_enq_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_LEN'(1);
            end
            if (w_deq_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_LEN'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_full_count);
            r_empty <= (w_count_nxt == '0);
            r_afull <= (w_count_nxt >= c_afull_count);
        end
    end

    assign data_out    = r_empty ? '0 : r_mem[r_rd_ptr];
    assign valid       = w_valid;
    assign full        = r_full;
    assign empty       = r_empty;
    assign almost_full = r_afull;
    assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_timed_event_fifo.sv
`default_nettype none
// Testbench for timed_event_fifo: queue-based reference model checked every
// cycle, plus directed literal checks on ordering, boundaries and wrap.
module tb_timed_event_fifo;

    localparam int N  = 256;
    localparam int AF = 240;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enqueue = 1'b0;
    logic        dequeue = 1'b0;
    logic [31:0] data_in = '0;
    logic [15:0] data_out;
    logic        valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic [8:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] pl;
        longint      rel;
    } ent_t;

    ent_t   q[$];
    longint m_cyc = 0;

    timed_event_fifo #(
        .DATA_WIDTH(16), .LT_WIDTH(16), .ADDR_LEN(8),
        .NUM_ENTRIES(N), .AFULL_LEVEL(AF)
    ) dut (
        .clk(clk), .reset(rst), .enqueue(enqueue), .dequeue(dequeue),
        .data_in(data_in), .data_out(data_out), .valid(valid), .full(full),
        .empty(empty), .almost_full(almost_full), .count(count)
    );

    always #5 clk = ~clk;

    // Absolute cycle numbers avoid modular arithmetic in the model.
    function automatic bit m_valid();
        return (q.size() > 0) && (m_cyc >= q[0].rel);
    endfunction

    task automatic model_edge();
        bit   dacc;
        bit   eacc;
        ent_t e;
        dacc = dequeue && m_valid();
        eacc = enqueue && ((q.size() < N) || dacc);
        if (dacc) void'(q.pop_front());
        if (eacc) begin
            e.pl = data_in[31:16];
`ifdef TIMED_FIFO_DELAY_EN
            e.rel = m_cyc + longint'(data_in[15:0]) + 1;
`else
            e.rel = 0;
`endif
            q.push_back(e);
        end
        m_cyc++;
    endtask

    task automatic tick(input logic e, input logic d, input logic [31:0] din);
        enqueue = e;
        dequeue = d;
        data_in = din;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    initial begin
        logic [15:0] e_do;
        logic [8:0]  e_cnt;
        logic        e_v;
        forever begin
            @(negedge clk);
            e_cnt = 9'(q.size());
            e_v   = m_valid();
            e_do  = (q.size() > 0) ? q[0].pl : 16'h0;
            total++;
            if (data_out !== e_do || valid !== e_v || count !== e_cnt ||
                full !== (q.size() == N) || empty !== (q.size() == 0) ||
                almost_full !== (q.size() >= AF)) begin
                bad++;
                $display("FAIL cycle t=%0t dout=%h/%h valid=%b/%b count=%0d/%0d full=%b empty=%b afull=%b (got/exp)",
                         $time, data_out, e_do, valid, e_v, count, e_cnt, full, empty, almost_full);
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        #1 rst = 1'b1;
        q.delete();
        m_cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_dout", 32'(data_out), 32'd0);
        rst = 1'b0;

        // In-order pops, lt=1
        tick(1, 0, {16'd10, 16'd1});
`ifdef TIMED_FIFO_DELAY_EN
        chk("s1_e0_valid", 32'(valid), 32'd0);
`else
        chk("s1_e0_valid", 32'(valid), 32'd1);
`endif
        tick(1, 0, {16'd11, 16'd1});
        tick(1, 0, {16'd12, 16'd1});
        chk("s1_head10", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'd10});
        tick(0, 1, '0);
        chk("s1_head11", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'd11});
        tick(0, 1, '0);
        chk("s1_head12", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'd12});
        tick(0, 1, '0);
        chk("s1_empty", {15'd0, empty, valid, data_out}, {15'd0, 1'b1, 1'b0, 16'd0});

        // Head-of-line blocking with mixed delays, dequeue held throughout
        tick(1, 1, {16'd10, 16'd1});
`ifdef TIMED_FIFO_DELAY_EN
        chk("s2_e0", {15'd0, valid, data_out}, {15'd0, 1'b0, 16'd10});
        tick(1, 1, {16'd11, 16'd4});
        chk("s2_e1", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'd10});
        tick(1, 1, {16'd12, 16'd2});
        chk("s2_e2", {15'd0, valid, data_out}, {15'd0, 1'b0, 16'd11});
        chk("s2_e2_count", 32'(count), 32'd2);
        tick(0, 1, '0);
        tick(0, 1, '0);
        chk("s2_e4", 32'(valid), 32'd0);
        tick(0, 1, '0);
        chk("s2_e5", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'd11});
        tick(0, 1, '0);
        chk("s2_e6", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'd12});
        tick(0, 1, '0);
        chk("s2_e7_empty", 32'(empty), 32'd1);
`else
        chk("s2_e0", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'd10});
        tick(1, 1, {16'd11, 16'd4});
        tick(1, 1, {16'd12, 16'd2});
        chk("s2_e2", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'd12});
        chk("s2_e2_count", 32'(count), 32'd1);
        tick(0, 1, '0);
        chk("s2_e3_empty", 32'(empty), 32'd1);
        repeat (4) tick(0, 1, '0);
`endif

        // Fill, overflow, simultaneous enqueue/dequeue at full, drain
        for (int i = 0; i < N; i++) begin
            tick(1, 0, {16'(i), 16'd0});
            if (i == AF - 2) chk("afull_at_239", 32'(almost_full), 32'd0);
            if (i == AF - 1) chk("afull_at_240", {23'd0, almost_full, count}, {23'd0, 1'b1, 9'd240});
        end
        chk("full_set", {23'd0, full, count}, {23'd0, 1'b1, 9'd256});
        tick(1, 0, {16'hBEEF, 16'd0});
        chk("full_drop", {7'd0, count, data_out}, {7'd0, 9'd256, 16'd0});
        tick(1, 1, {16'hCAFE, 16'd0});
        chk("full_enq_deq", {6'd0, full, count, data_out}, {6'd0, 1'b1, 9'd256, 16'd1});
        for (int i = 0; i < N; i++) begin
            tick(0, 1, '0);
            if (i == N - 2) chk("tail_cafe", 32'(data_out), 32'h0000CAFE);
        end
        chk("drained", {30'd0, empty, full}, {30'd0, 1'b1, 1'b0});

        // Long delay entry
        tick(1, 0, {16'h0ABC, 16'd100});
`ifdef TIMED_FIFO_DELAY_EN
        chk("lt100_first", 32'(valid), 32'd0);
        repeat (99) tick(0, 0, '0);
        chk("lt100_99", 32'(valid), 32'd0);
        tick(0, 0, '0);
        chk("lt100_100", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'h0ABC});
`else
        chk("lt100_first", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'h0ABC});
`endif
        tick(0, 1, '0);
        chk("lt100_pop", 32'(empty), 32'd1);

        // Timestamp wrap: enqueue lt=5 while now = 0xFFFD
        guard = 0;
        while (((m_cyc & 64'hFFFF) != 64'hFFFD) && guard < 70000) begin
            tick(0, 0, '0);
            guard++;
        end
        chk("wrap_reached", 32'(guard < 70000), 32'd1);
        tick(1, 0, {16'h0777, 16'd5});
`ifdef TIMED_FIFO_DELAY_EN
        repeat (4) tick(0, 0, '0);
        chk("wrap_before", 32'(valid), 32'd0);
        tick(0, 0, '0);
        chk("wrap_release", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'h0777});
`else
        chk("wrap_release", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'h0777});
`endif
        tick(0, 1, '0);
        chk("wrap_pop", 32'(empty), 32'd1);

        // Asynchronous reset with entries queued
        for (int i = 0; i < 5; i++) tick(1, 0, {16'h0020 + 16'(i), 16'd3});
        chk("pre_reset_count", 32'(count), 32'd5);
        #2 rst = 1'b1;
        q.delete();
        m_cyc = 0;
        #1;
        chk("async_reset", {14'd0, empty, valid, full, almost_full, count, data_out},
                           {14'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 16'd0});
        @(posedge clk);
        #1 rst = 1'b0;
        tick(1, 0, {16'h0055, 16'd0});
        chk("post_reset_head", {15'd0, valid, data_out}, {15'd0, 1'b1, 16'h0055});
        tick(0, 1, '0);
        chk("post_reset_pop", 32'(empty), 32'd1);

        repeat (2) tick(0, 0, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
